// File: rtl/pool_requant_buffer_pkg.sv
// Shared types and width helpers for the pooled-stream requant buffer.
package pool_requant_buffer_pkg;

  // Layer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Word counters must be able to hold TOTAL itself
  function automatic int cnt_w(input int total);
    return $clog2(total + 1);
  endfunction

  // FIFO pointers carry one extra wrap bit to tell full from empty
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: head word is visible whenever empty is low.
module sync_fifo
  import pool_requant_buffer_pkg::*;
#(
  parameter int DATA  = 17,
  parameter int DEPTH = 16
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            wr_do, rd_do;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees a slot in the same cycle, so a write at full still lands
  assign wr_do   = wr_en && (!full || rd_en);
  assign rd_do   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk1) begin
    if (wr_do) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pool_requant_buffer.sv
// Requantises the pooled 32-bit stream to IFM_WIDTH (round, shift, saturate),
// buffers it for the next layer's loader and tracks layer completion/errors.
module pool_requant_buffer
  import pool_requant_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int OUT_SIZE   = 13,
  parameter int CO         = 8,
  parameter int DEPTH      = 16
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                 in_end,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IFM_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 layer_done,
  output logic                 overflow,
  output logic                 count_err
);

  localparam int TOTAL = OUT_SIZE * OUT_SIZE * CO;
  localparam int CW    = cnt_w(TOTAL);
  localparam logic [CW-1:0] TOT    = CW'(TOTAL);
  localparam logic [CW-1:0] TOT_M1 = CW'(TOTAL - 1);

  // Rounding constant is half an output LSB; zero when there is no shift
  localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [DATA_WIDTH:0] RND =
    (SHIFT > 0) ? ((DATA_WIDTH+1)'(1) << SH_M1) : '0;
  localparam logic signed [DATA_WIDTH:0] MAXV =
    {{(DATA_WIDTH+2-IFM_WIDTH){1'b0}}, {(IFM_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] MINV =
    {{(DATA_WIDTH+2-IFM_WIDTH){1'b1}}, {(IFM_WIDTH-1){1'b0}}};

  state_t                state;
  logic [CW-1:0]         in_cnt, out_cnt, in_cnt_nxt;
  logic signed [DATA_WIDTH:0] rq_t, rq_s;
  logic [IFM_WIDTH-1:0]  rq_sat, rq_data;
  logic                  rq_vld, accept, pop;
  logic                  fifo_full, fifo_empty;

  // Requant datapath: one extra bit so the rounding add cannot wrap
  always_comb begin
    rq_t = $signed({in_data[DATA_WIDTH-1], in_data}) + RND;
    rq_s = rq_t >>> SHIFT;
    if (rq_s > MAXV)      rq_sat = MAXV[IFM_WIDTH-1:0];
    else if (rq_s < MINV) rq_sat = MINV[IFM_WIDTH-1:0];
    else                  rq_sat = rq_s[IFM_WIDTH-1:0];
  end

  // Words arriving after the layer is complete never enter the pipe
  assign accept     = in_valid && (state == ST_IDLE || state == ST_RUN);
  assign in_cnt_nxt = in_cnt + 1'b1;
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign out_last   = out_valid && (out_cnt == TOT_M1);

  // Stage-1 register holding the requantised word for the FIFO write
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rq_vld  <= 1'b0;
      rq_data <= '0;
    end else begin
      rq_vld <= accept;
      if (accept) rq_data <= rq_sat;
    end
  end

  sync_fifo #(
    .DATA  (IFM_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .wr_en   (rq_vld),
    .wr_data (rq_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Layer FSM with counters and registered status flags
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      layer_done <= 1'b0;
      overflow   <= 1'b0;
      count_err  <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (rq_vld && fifo_full && !pop) overflow <= 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (in_valid) begin
            in_cnt <= in_cnt_nxt;
            state  <= (in_cnt_nxt == TOT) ? ST_DRAIN : ST_RUN;
          end
          // An end marker on the TOTAL-th word is the normal case
          if (in_end && (in_valid || state == ST_RUN) &&
              !(in_valid && in_cnt_nxt == TOT)) begin
            count_err <= 1'b1;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (in_valid) count_err <= 1'b1;
          // Short layers finish once both the stage-1 reg and FIFO are empty
          if ((pop && out_cnt == TOT_M1) || (fifo_empty && !rq_vld)) begin
            state      <= ST_DONE;
            layer_done <= 1'b1;
          end
        end
        default: begin
          if (in_valid) count_err <= 1'b1;
          in_cnt  <= '0;
          out_cnt <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
